// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and hazard_ctrl (slave).
// Inputs describe the instruction in ID plus EX/MEM status; outputs steer the pipeline registers.
interface hazard_ctrl_if #(parameter int CNT_W = 16) ();
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_re1;
  logic             id_re2;
  logic [4:0]       id_rd;
  logic             id_we;
  logic             id_load;
  logic             br_taken;
  logic             mem_busy;
  logic             stall_if;
  logic             stall_id;
  logic             flush_id;
  logic             bubble_ex;
  logic             freeze;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_re1, id_re2, id_rd, id_we, id_load, br_taken, mem_busy,
    input  stall_if, stall_id, flush_id, bubble_ex, freeze, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_re1, id_re2, id_rd, id_we, id_load, br_taken, mem_busy,
    output stall_if, stall_id, flush_id, bubble_ex, freeze, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: load-use stall, branch flush, memory freeze, EX operand forwarding.
// Control outputs are combinational; fwd_a/b are registered as the ID instruction advances into EX.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  logic [4:0]       ex_rd, mem_rd, wb_rd;
  logic             ex_we, ex_ld, mem_we, wb_we;
  logic [1:0]       fwd_a, fwd_b;
  logic [1:0]       fwd_a_nxt, fwd_b_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             lu;
  logic             bubble_adv;

  // WB producers are covered by the write-first register file, so they select the regfile.
  function automatic logic [1:0] fwd_sel(
    input logic       re,
    input logic [4:0] rs,
    input logic [4:0] e_rd,  input logic e_we,
    input logic [4:0] m_rd,  input logic m_we,
    input logic [4:0] w_rd,  input logic w_we
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (re && rs != 5'd0) begin
      if (e_we && rs == e_rd)      sel = 2'b01;
      else if (m_we && rs == m_rd) sel = 2'b10;
      else if (w_we && rs == w_rd) sel = 2'b00;
    end
    return sel;
  endfunction

  always_comb begin
    lu = !rst && ex_ld && ex_we && (ex_rd != 5'd0) &&
         ((hz.id_re1 && hz.id_rs1 == ex_rd) || (hz.id_re2 && hz.id_rs2 == ex_rd));
    bubble_adv = hz.br_taken || lu;

    fwd_a_nxt = fwd_sel(hz.id_re1, hz.id_rs1, ex_rd, ex_we, mem_rd, mem_we, wb_rd, wb_we);
    fwd_b_nxt = fwd_sel(hz.id_re2, hz.id_rs2, ex_rd, ex_we, mem_rd, mem_we, wb_rd, wb_we);

    hz.stall_if  = 1'b0;
    hz.stall_id  = 1'b0;
    hz.flush_id  = 1'b0;
    hz.bubble_ex = 1'b0;
    hz.freeze    = hz.mem_busy;
    if (hz.mem_busy) begin
      hz.stall_if = 1'b1;
      hz.stall_id = 1'b1;
    end else if (hz.br_taken) begin
      hz.flush_id  = 1'b1;
      hz.bubble_ex = 1'b1;
    end else if (lu) begin
      hz.stall_if  = 1'b1;
      hz.stall_id  = 1'b1;
      hz.bubble_ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rd     <= 5'd0;
      ex_we     <= 1'b0;
      ex_ld     <= 1'b0;
      mem_rd    <= 5'd0;
      mem_we    <= 1'b0;
      wb_rd     <= 5'd0;
      wb_we     <= 1'b0;
      fwd_a     <= 2'b00;
      fwd_b     <= 2'b00;
      stall_cnt <= '0;
    end else if (!hz.mem_busy) begin
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      if (bubble_adv) begin
        ex_rd <= 5'd0;
        ex_we <= 1'b0;
        ex_ld <= 1'b0;
        fwd_a <= 2'b00;
        fwd_b <= 2'b00;
      end else begin
        ex_rd <= hz.id_rd;
        ex_we <= hz.id_we;
        ex_ld <= hz.id_load;
        fwd_a <= fwd_a_nxt;
        fwd_b <= fwd_b_nxt;
      end
      // A branch squashes the stalled instruction, so only true load-use stalls are counted.
      if (lu && !hz.br_taken && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign hz.fwd_a     = fwd_a;
  assign hz.fwd_b     = fwd_b;
  assign hz.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios then random traffic against a queue-based pipeline model.
// A second narrow-counter instance shares the stimulus so saturation is reached in few cycles.
module tb_hazard_ctrl;
  localparam int SAT_W = 4;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } ins_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16))    hz ();
  hazard_ctrl_if #(.CNT_W(SAT_W)) hz_s ();

  hazard_ctrl #(.CNT_W(16))    dut     (.clk(clk), .rst(rst), .hz(hz));
  hazard_ctrl #(.CNT_W(SAT_W)) dut_sat (.clk(clk), .rst(rst), .hz(hz_s));

  assign hz_s.id_rs1   = hz.id_rs1;
  assign hz_s.id_rs2   = hz.id_rs2;
  assign hz_s.id_re1   = hz.id_re1;
  assign hz_s.id_re2   = hz.id_re2;
  assign hz_s.id_rd    = hz.id_rd;
  assign hz_s.id_we    = hz.id_we;
  assign hz_s.id_load  = hz.id_load;
  assign hz_s.br_taken = hz.br_taken;
  assign hz_s.mem_busy = hz.mem_busy;

  // pipe[0] is the instruction in EX, pipe[1] in MEM, pipe[2] in WB.
  ins_t        pipe[$];
  logic [1:0]  fa_m, fb_m;
  int unsigned cnt_m, cnt_s;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Youngest in-flight writer of rs wins; EX producer selects MEM-stage data, MEM producer WB data.
  function automatic logic [1:0] fwd_of(input logic re, input logic [4:0] rs);
    if (!re || rs == 5'd0) return 2'b00;
    for (int k = 0; k < 2; k++)
      if (pipe[k].we && pipe[k].rd == rs) return 2'(k + 1);
    return 2'b00;
  endfunction

  task automatic model_reset();
    pipe = {ins_t'(0), ins_t'(0), ins_t'(0)};
    fa_m = 2'b00;
    fb_m = 2'b00;
    cnt_m = 0;
    cnt_s = 0;
  endtask

  task automatic step(input logic [4:0] rs1, input logic re1, input logic [4:0] rs2, input logic re2,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic br, input logic busy, input logic r);
    logic       lu;
    logic [4:0] ctl;
    ins_t       nxt;
    hz.id_rs1 = rs1;  hz.id_re1 = re1;
    hz.id_rs2 = rs2;  hz.id_re2 = re2;
    hz.id_rd  = rd;   hz.id_we  = we;   hz.id_load = ld;
    hz.br_taken = br; hz.mem_busy = busy; rst = r;

    lu = !r && pipe[0].ld && pipe[0].we && pipe[0].rd != 5'd0 &&
         ((re1 && rs1 == pipe[0].rd) || (re2 && rs2 == pipe[0].rd));
    // {stall_if, stall_id, flush_id, bubble_ex, freeze}
    if (busy)     ctl = 5'b11001;
    else if (br)  ctl = 5'b00110;
    else if (lu)  ctl = 5'b11010;
    else          ctl = 5'b00000;

    @(negedge clk);
    check("ctl", 32'({hz.stall_if, hz.stall_id, hz.flush_id, hz.bubble_ex, hz.freeze}), 32'(ctl));
    check("fwd", 32'({hz.fwd_a, hz.fwd_b}), 32'({fa_m, fb_m}));
    check("stall_cnt", 32'(hz.stall_cnt), cnt_m);
    check("stall_cnt_sat", 32'(hz_s.stall_cnt), cnt_s);

    if (r) begin
      model_reset();
    end else if (!busy) begin
      if (br || lu) begin
        nxt = '0;
        fa_m = 2'b00;
        fb_m = 2'b00;
        if (!br) begin
          if (cnt_m < 32'hFFFF) cnt_m++;
          if (cnt_s < (1 << SAT_W) - 1) cnt_s++;
        end
      end else begin
        nxt = {rd, we, ld};
        fa_m = fwd_of(re1, rs1);
        fb_m = fwd_of(re2, rs2);
      end
      pipe.push_front(nxt);
      void'(pipe.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  // Shorthands: load rd <- [rs1], ALU rd <- rs1 op rs2, nop.
  task automatic ld_i(input logic [4:0] rd, input logic [4:0] rs1);
    step(rs1, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic alu_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    step(rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic nop_i();
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_re1 = 1'b0; hz.id_re2 = 1'b0;
    hz.id_rd = '0;  hz.id_we = 1'b0; hz.id_load = 1'b0;
    hz.br_taken = 1'b0; hz.mem_busy = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Load followed by dependent add: one stall, then the add is forwarded.
    ld_i(5'd5, 5'd2);
    alu_i(5'd6, 5'd5, 5'd1);
    alu_i(5'd6, 5'd5, 5'd1);
    nop_i(); nop_i();

    // Back-to-back ALU dependency, then with one independent instruction between.
    alu_i(5'd5, 5'd1, 5'd2);
    alu_i(5'd7, 5'd1, 5'd5);
    nop_i();
    alu_i(5'd5, 5'd1, 5'd2);
    alu_i(5'd8, 5'd3, 5'd4);
    alu_i(5'd7, 5'd1, 5'd5);
    nop_i(); nop_i();

    // x0 is never a hazard.
    ld_i(5'd0, 5'd1);
    alu_i(5'd6, 5'd0, 5'd0);
    nop_i(); nop_i();

    // Load-use coinciding with a taken branch.
    ld_i(5'd5, 5'd2);
    step(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    nop_i(); nop_i();

    // Memory busy for three cycles during a load-use condition.
    ld_i(5'd5, 5'd2);
    repeat (3) step(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    alu_i(5'd6, 5'd5, 5'd1);
    alu_i(5'd6, 5'd5, 5'd1);
    nop_i();

    // Reset in the middle of a stall.
    ld_i(5'd5, 5'd2);
    step(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    alu_i(5'd6, 5'd5, 5'd1);
    nop_i();

    // Chained loads reading their own destination: a stall every other cycle drives saturation.
    repeat (40) ld_i(5'd5, 5'd5);
    nop_i(); nop_i();

    for (int i = 0; i < 4000; i++) begin
      step(5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 8),
           5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 8),
           5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) < 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
